// File: rtl/btn_filter_scheduler.sv
// ---------------------------------------------------------------------------
// btn_filter_scheduler
//
// Purpose:
//   Debounces NUM_BUTTONS raw push-button inputs using one shared delay
//   counter. Each raw input passes through a two-flop synchronizer. A button
//   is a candidate for filtering while its synchronized level differs from
//   its accepted (filtered) level. A round-robin scheduler grants the shared
//   counter to one candidate at a time. The granted button's filtered level
//   flips only after the new level has held for FILTER_CYCLES clocks.
//   Each flip produces a one-cycle press or release pulse.
//
// Ports:
//   clockSource  - system clock; all logic is on the rising edge
//   reset        - synchronous, active-high reset
//   rawButtons   - asynchronous raw button levels
//   buttonState  - filtered stable levels
//   pressPulse   - one-cycle pulse on a 0->1 change of buttonState
//   releasePulse - one-cycle pulse on a 1->0 change of buttonState
//   busy         - high while the shared counter is granted
//   activeIndex  - index of the granted button; holds its value when idle
//
// Parameters:
//   NUM_BUTTONS   - number of button inputs (2..16)
//   FILTER_CYCLES - clocks a new level must hold before it is accepted (>=2)
//   CNT_WIDTH     - shared counter width, 2**CNT_WIDTH >= FILTER_CYCLES
//   IDX_WIDTH     - button index width,   2**IDX_WIDTH >= NUM_BUTTONS
// ---------------------------------------------------------------------------
module btn_filter_scheduler #(
  parameter int NUM_BUTTONS   = 4,
  parameter int FILTER_CYCLES = 10000,
  parameter int CNT_WIDTH     = 14,
  parameter int IDX_WIDTH     = 2
) (
  input  logic                   clockSource,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] rawButtons,
  output logic [NUM_BUTTONS-1:0] buttonState,
  output logic [NUM_BUTTONS-1:0] pressPulse,
  output logic [NUM_BUTTONS-1:0] releasePulse,
  output logic                   busy,
  output logic [IDX_WIDTH-1:0]   activeIndex
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TIMING = 2'd1,
    COMMIT = 2'd2
  } schedStateT;

  // Terminal count of the shared counter and the highest legal button index.
  localparam logic [CNT_WIDTH-1:0] CountLast = CNT_WIDTH'(FILTER_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] LastIndex = IDX_WIDTH'(NUM_BUTTONS - 1);

  // Synchronizer stages
  logic [NUM_BUTTONS-1:0] r_syncMeta;
  logic [NUM_BUTTONS-1:0] r_syncBtn;

  // Scheduler / filter state
  schedStateT             r_state;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [IDX_WIDTH-1:0]   r_rrPtr;
  logic [IDX_WIDTH-1:0]   r_activeIndex;
  logic                   r_busy;
  logic [NUM_BUTTONS-1:0] r_buttonState;
  logic [NUM_BUTTONS-1:0] r_pressPulse;
  logic [NUM_BUTTONS-1:0] r_releasePulse;

  // Combinational helpers
  logic [NUM_BUTTONS-1:0] w_mismatch;
  logic                   w_found;
  logic [IDX_WIDTH-1:0]   w_grantIdx;
  logic [IDX_WIDTH-1:0]   w_candIdx;
  logic [IDX_WIDTH-1:0]   w_nextPtr;
  logic [NUM_BUTTONS-1:0] w_activeOneHot;
  logic                   w_activeStable;

  // Two-flop synchronizer. Only r_syncBtn is used for decisions; r_syncMeta
  // absorbs metastability from the asynchronous pins.
  always_ff @(posedge clockSource) begin
    if (reset) begin
      r_syncMeta <= '0;
      r_syncBtn  <= '0;
    end else begin
      r_syncMeta <= rawButtons;
      r_syncBtn  <= r_syncMeta;
    end
  end

  // A set bit means the synchronized level disagrees with the accepted level.
  // That button needs a turn on the shared counter.
  assign w_mismatch = r_syncBtn ^ r_buttonState;

  // Round-robin pick: walk the indices starting at r_rrPtr and wrap at
  // NUM_BUTTONS. The first mismatched button wins. The candidate index
  // advances with an explicit wrap, so NUM_BUTTONS need not be a power of two.
  always_comb begin
    w_found    = 1'b0;
    w_grantIdx = '0;
    w_candIdx  = r_rrPtr;
    for (int offset = 0; offset < NUM_BUTTONS; offset++) begin
      if (!w_found && w_mismatch[w_candIdx]) begin
        w_found    = 1'b1;
        w_grantIdx = w_candIdx;
      end
      w_candIdx = (w_candIdx == LastIndex) ? '0 : w_candIdx + 1'b1;
    end
  end

  // The pointer moves just past the button that last held the counter.
  // This rotation is what keeps every button from being starved.
  assign w_nextPtr = (r_activeIndex == LastIndex) ? '0 : r_activeIndex + 1'b1;

  // One-hot mask of the granted button, used for the commit flip and pulses.
  assign w_activeOneHot = NUM_BUTTONS'(1) << r_activeIndex;

  // True when the granted button's input has fallen back to its accepted
  // level, which means it bounced and its timing must be abandoned.
  assign w_activeStable = (r_syncBtn[r_activeIndex] == r_buttonState[r_activeIndex]);

  // Scheduler FSM with registered outputs.
  // IDLE grants the counter to a mismatched button. TIMING counts while the
  // new level holds and aborts on a bounce. COMMIT flips the accepted level
  // and fires the matching pulse on the same edge. Pulses default low every
  // cycle, so each pulse lasts exactly one clock. Reset overrides any state,
  // so an operation cut short by reset never produces a pulse.
  always_ff @(posedge clockSource) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_rrPtr        <= '0;
      r_activeIndex  <= '0;
      r_busy         <= 1'b0;
      r_buttonState  <= '0;
      r_pressPulse   <= '0;
      r_releasePulse <= '0;
    end else begin
      r_pressPulse   <= '0;
      r_releasePulse <= '0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_activeIndex <= w_grantIdx;
            r_count       <= '0;
            r_state       <= TIMING;
            r_busy        <= 1'b1;
          end
        end
        TIMING: begin
          if (w_activeStable) begin
            r_rrPtr <= w_nextPtr;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_count == CountLast) begin
            r_state <= COMMIT;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        COMMIT: begin
          r_buttonState  <= r_buttonState ^ w_activeOneHot;
          r_pressPulse   <= w_activeOneHot & ~r_buttonState;
          r_releasePulse <= w_activeOneHot & r_buttonState;
          r_rrPtr        <= w_nextPtr;
          r_state        <= IDLE;
          r_busy         <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign buttonState  = r_buttonState;
  assign pressPulse   = r_pressPulse;
  assign releasePulse = r_releasePulse;
  assign busy         = r_busy;
  assign activeIndex  = r_activeIndex;

endmodule
